// File: rtl/score_pkg.sv
// Shared types and constants for the score counter bank: FSM state encoding,
// counting-mode constants and the winner-index width helper.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2
    } state_e;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Winner index needs at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_counter_bank_if.sv
// Control/score bus between game logic and the score counter bank.
// master drives the controls and strobes; slave is the counter bank.
interface score_counter_bank_if #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 4
);
    import score_pkg::*;
    localparam int CH_W = ch_w(NUM_CH);

    logic                    en;
    logic                    start;
    logic                    clear;
    logic                    mode_sat;
    logic [WIDTH-1:0]        limit;
    logic [NUM_CH-1:0]       score_update;
    logic [NUM_CH*WIDTH-1:0] q;
    logic [NUM_CH-1:0]       wrap_pulse;
    logic                    win;
    logic [CH_W-1:0]         winner;

    modport master (
        output en, start, clear, mode_sat, limit, score_update,
        input  q, wrap_pulse, win, winner
    );

    modport slave (
        input  en, start, clear, mode_sat, limit, score_update,
        output q, wrap_pulse, win, winner
    );

endinterface

// File: rtl/score_edge_detect.sv
// Rising-edge detector for one score strobe. With SCORE_SYNC_EN defined the
// input first crosses a 2-flop synchroniser; otherwise it is assumed synchronous.
module score_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic ev
);

`ifdef SCORE_SYNC_EN
    logic sync1_q, sync2_q, hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign ev = sync2_q & ~hist_q;
`else
    logic hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= din;
        end
    end

    assign ev = din & ~hist_q;
`endif

endmodule

// File: rtl/score_counter_bank.sv
// Bank of per-player score counters with an IDLE/PLAY/WIN game FSM.
// Optional input synchroniser selected by SCORE_SYNC_EN (see score_edge_detect).
module score_counter_bank
    import score_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    score_counter_bank_if.slave  bus
);

    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0] ev;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_edge
        score_edge_detect u_edge (
            .clk (clk),
            .rst (rst),
            .din (bus.score_update[g]),
            .ev  (ev[g])
        );
    end

    state_e                        state_q, state_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  q_q, q_d;
    logic [NUM_CH-1:0]             wrap_q, wrap_d;
    logic [CH_W-1:0]               winner_q, winner_d;
    logic [WIDTH-1:0]              nv;
    logic                          hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            wrap_q   <= '0;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            wrap_q   <= wrap_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        wrap_d   = '0;
        winner_d = winner_q;
        nv       = '0;
        hit      = 1'b0;

        if (bus.clear) begin
            state_d = S_IDLE;
            q_d     = '0;
        end else if (bus.start) begin
            state_d = S_PLAY;
            q_d     = '0;
        end else if (state_q == S_PLAY && bus.en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ev[i]) begin
                    // A count already at/above a (possibly lowered) limit hits the terminal rule.
                    if (q_q[i] >= bus.limit) begin
                        nv        = (bus.mode_sat == MODE_SAT) ? bus.limit : '0;
                        wrap_d[i] = (bus.mode_sat == MODE_WRAP);
                    end else begin
                        nv = q_q[i] + WIDTH'(1);
                    end
                    q_d[i] = nv;
                    // Ascending scan: the lowest-indexed simultaneous hit claims the win.
                    if (bus.mode_sat == MODE_SAT && nv == bus.limit && !hit) begin
                        hit      = 1'b1;
                        winner_d = CH_W'(i);
                    end
                end
            end
            if (hit) begin
                state_d = S_WIN;
            end
        end
    end

    assign bus.q          = q_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.win        = (state_q == S_WIN);
    assign bus.winner     = winner_q;

endmodule

// File: doc/score_counter_bank.md
Name: score_counter_bank

Overview:
Parametrised bank of NUM_CH per-player score counters clocked by the system clock. Each channel counts rising edges of its score_update strobe up to a programmable limit. A small game FSM (IDLE/PLAY/WIN) reports the first player to reach the limit. The block sits between the game-logic event sources and the score display/seven-segment drivers.

Parameters:
NUM_CH, 2, number of independent score channels (1..8)
WIDTH, 4, bits per score counter
CH_W, $clog2(NUM_CH) (min 1), width of winner index (derived localparam)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high; clears all state
en  in  1  count enable; score events ignored while low
start  in  1  synchronous pulse: clear all counters, enter PLAY
clear  in  1  synchronous: clear all counters, enter IDLE (priority over start)
mode_sat  in  1  1 = saturate at limit and declare winner; 0 = wrap to 0
limit  in  WIDTH  terminal score (shared by all channels)
score_update  in  NUM_CH  per-channel event strobes (level, one bit per player)
q  out  NUM_CH*WIDTH  packed scores, channel i at [i*WIDTH +: WIDTH]
wrap_pulse  out  NUM_CH  one-cycle pulse when channel i wraps (wrap mode only)
win  out  1  high while FSM in WIN
winner  out  CH_W  index of winning channel, valid while win=1

Behaviour:
- Reset: q=0, wrap_pulse=0, win=0, winner=0, FSM=IDLE, edge-detect history=0.
- Event: ev[i] = rising edge of score_update[i] (see Optional Feature for latency). Level held high = one event only.
- Counting happens only when en=1 and FSM=PLAY; otherwise events are discarded (not queued).
- Per-channel next value on ev[i]: if q_i >= limit -> (mode_sat ? limit : 0), else q_i+1. All arithmetic is WIDTH-bit unsigned; q never exceeds max(limit, previous q).
- Limit lowered mid-play below q_i: q_i unchanged until its next event, then handled by the q_i >= limit rule.
- wrap_pulse[i]=1 for exactly one cycle, on the edge where q_i is forced to 0 by the wrap rule (mode_sat=0).
- FSM:
  - IDLE -> PLAY on start (counters cleared the same edge).
  - PLAY -> WIN in sat mode on the edge where any channel's next value equals limit due to an event. winner latches that channel; on simultaneous hits the lowest index wins. Counters update the same edge.
  - WIN: all counting frozen. start -> PLAY (counters cleared, win=0). clear -> IDLE.
  - PLAY/WIN/IDLE -> IDLE on clear (counters cleared); clear overrides start.
- limit=0, sat mode: the first counted event keeps q=0 and moves to WIN. limit=0, wrap mode: every event pulses wrap_pulse and q stays 0.
- mode_sat changes take effect on the next event; no retroactive action.
- Async rst mid-game: immediate return to the reset state, independent of clk.

Optional Feature:
SCORE_SYNC_EN
- Defined: each score_update bit passes through a 2-flop synchroniser before edge detection. q updates on the third clk edge at which the input is sampled high (edge k: sync1, k+1: sync2, k+2: update).
- Undefined: inputs are assumed synchronous to clk with a single history flop. q updates on the first clk edge at which the input is sampled high after being low.

Decomposition:
- Package score_pkg: FSM state localparams (S_IDLE=2'd0, S_PLAY=2'd1, S_WIN=2'd2) and the sat/wrap mode constants.
- Sub-module score_edge_detect: one per channel via generate. Optional sync, history flop, ev output; reset to 0.
- Counters and FSM stay in the top module.

Test Plan:
- Reset then start, en=1, mode_sat=0, limit=3, five pulses on ch0 -> q0 = 1,2,3,0,1; wrap_pulse[0] high once at the 3->0 step; win stays 0.
- mode_sat=1, limit=2, two pulses ch1 -> win=1, winner=1, q1=2; further pulses on ch0 and ch1 -> q unchanged.
- Same-cycle pulses on ch0 and ch1 with both at limit-1, sat mode -> win=1, winner=0, q0=q1=limit.
- en=0 during pulses, or a pulse held high for 10 cycles -> zero counts, and exactly one count respectively.
- Assert start and clear together in WIN -> FSM=IDLE, q=0, win=0; later pulses ignored until start.
- Async rst asserted mid-cycle in PLAY with q0=2 -> q=0, win=0 immediately, before the next clk edge; check both SCORE_SYNC_EN builds for update latency (3 edges vs 1 edge).
